// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the memory-mapped UART transmitter and its FIFO:
//   - register byte offsets (THR, LSR, LVL)
//   - line-status register bit positions
//   - transmit FSM state encoding
//   - helper that packs the line-status word
// -----------------------------------------------------------------------------
package uart_pkg;

  // Register byte offsets on the peripheral bus
  localparam logic [4:0] UART_THR = 5'h00;
  localparam logic [4:0] UART_LSR = 5'h14;
  localparam logic [4:0] UART_LVL = 5'h18;

  // Line-status register bit positions
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  // Transmit sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Build the 32-bit LSR read value; every bit other than OE/THRE/TEMT is 0
  function automatic logic [31:0] lsr_pack(input logic oe,
                                           input logic thre,
                                           input logic temt);
    logic [31:0] word;
    word           = 32'h0000_0000;
    word[LSR_OE]   = oe;
    word[LSR_THRE] = thre;
    word[LSR_TEMT] = temt;
    return word;
  endfunction

endpackage

// File: rtl/uart_tx_model_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock circular-buffer FIFO. Pointers are LOG2 bits wide and wrap at
// the depth; occupancy is tracked in a separate LOG2+1 bit counter so that a
// completely full buffer is distinguishable from an empty one.
//
// Ports:
//   clk        in   clock
//   nreset     in   asynchronous active-low reset (contents discarded)
//   push       in   write request; ignored while full
//   push_data  in   WIDTH-bit data to store
//   pop        in   read request; ignored while empty
//   pop_data   out  head-of-queue data (valid while not empty)
//   full       out  registered, count == depth
//   empty      out  registered, count == 0
//   count      out  registered occupancy, 0..depth
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LOG2:0]    count
);

  localparam int            DEPTH      = 1 << LOG2;
  localparam logic [LOG2:0] FULL_COUNT = (LOG2+1)'(DEPTH);
  localparam logic [LOG2:0] CNT_ONE    = (LOG2+1)'(1);
  localparam logic [LOG2-1:0] PTR_ONE  = LOG2'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [LOG2-1:0]  wr_ptr_r;
  logic [LOG2-1:0]  rd_ptr_r;
  logic [LOG2:0]    count_r;
  logic [LOG2:0]    count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against the current (pre-update) flags and derive next occupancy
  always_comb begin
    push_ok_s   = push & ~full_r;
    pop_ok_s    = pop & ~empty_r;
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; not reset, stale entries are never exposed because empty gates reads
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and the flags derived from the next occupancy
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_COUNT);
      empty_r <= (count_nxt_s == '0);
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = empty_r;
  assign count    = count_r;

endmodule

// File: rtl/uart_tx_model.sv
// -----------------------------------------------------------------------------
// uart_tx_model
// Memory-mapped 8N1 UART transmitter. Bytes written to THR are queued in a
// FIFO and serialised LSB-first on tx (start 0, 8 data bits, stop 1), each bit
// lasting CLKDIV clocks. Frames are sent back-to-back while data is queued.
//
// Ports:
//   clk     in   system clock
//   nreset  in   asynchronous active-low reset
//   cs      in   peripheral select (qualifies wr)
//   addr    in   5-bit byte register offset
//   wr      in   write strobe
//   wdata   in   write data, only [7:0] is used (THR)
//   rd      in   read strobe
//   rdata   out  registered read data, refreshed every clock from addr
//   rvalid  out  one-cycle pulse the cycle after rd
//   tx      out  serial line, idle high, driven from a flop
//   irq     out  high while the FIFO is empty (THRE)
//
// Registers: 0x00 THR (write-only, reads 0), 0x14 LSR {TEMT,THRE,OE},
//            0x18 LVL (FIFO occupancy). Other offsets read 0.
// -----------------------------------------------------------------------------
module uart_tx_model
  import uart_pkg::*;
#(
  parameter int CLKDIV    = 16,
  parameter int FIFO_LOG2 = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic        rd,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        tx,
  output logic        irq
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKDIV - 1);

  // Transmit sequencer state
  tx_state_e        state_r;
  logic [15:0]      baud_cnt_r;
  logic [7:0]       shift_r;
  logic [2:0]       bit_idx_r;
  logic             tx_r;

  // Bus-side state
  logic             oe_r;
  logic [31:0]      rdata_r;
  logic             rvalid_r;

  // FIFO interface
  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic [7:0]       fifo_rdata_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [FIFO_LOG2:0] fifo_count_s;

  // Decode helpers
  logic             baud_done_s;
  logic             oe_set_s;
  logic             oe_clr_s;
  logic [31:0]      rd_mux_s;
  logic             unused_wdata_s;

  // Only the low byte of a THR write carries data
  assign unused_wdata_s = ^wdata[31:8];

  sync_fifo #(
    .WIDTH (8),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (fifo_push_s),
    .push_data (wdata[7:0]),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_rdata_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Bus write decode and OE bookkeeping; full is judged before any same-cycle pop
  always_comb begin
    fifo_push_s = cs & wr & (addr == UART_THR);
    oe_set_s    = fifo_push_s & fifo_full_s;
    // OE clears on the edge where rvalid rises for an LSR read
    oe_clr_s    = rd & ~rvalid_r & (addr == UART_LSR);
  end

  // Pop decision: from IDLE immediately, or at the end of STOP to chain frames
  always_comb begin
    baud_done_s = (baud_cnt_r == 16'd0);
    fifo_pop_s  = 1'b0;
    case (state_r)
      ST_IDLE: fifo_pop_s = ~fifo_empty_s;
      ST_STOP: fifo_pop_s = ~fifo_empty_s & baud_done_s;
      default: fifo_pop_s = 1'b0;
    endcase
  end

  // Transmit sequencer: start bit, 8 data bits LSB first, stop bit, with tx registered
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= 16'd0;
      shift_r    <= 8'd0;
      bit_idx_r  <= 3'd0;
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (fifo_pop_s) begin
            shift_r    <= fifo_rdata_s;
            tx_r       <= 1'b0;
            baud_cnt_r <= BAUD_RELOAD;
            state_r    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done_s) begin
            baud_cnt_r <= BAUD_RELOAD;
            tx_r       <= shift_r[0];
            bit_idx_r  <= 3'd0;
            state_r    <= ST_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_done_s) begin
            baud_cnt_r <= BAUD_RELOAD;
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              // shift_r[1] is the next bit once the register moves right by one
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_done_s) begin
            if (fifo_pop_s) begin
              shift_r    <= fifo_rdata_s;
              tx_r       <= 1'b0;
              baud_cnt_r <= BAUD_RELOAD;
              state_r    <= ST_START;
            end else begin
              tx_r       <= 1'b1;
              baud_cnt_r <= 16'd0;
              state_r    <= ST_IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          baud_cnt_r <= 16'd0;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overrun flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      oe_r <= 1'b0;
    end else if (oe_set_s) begin
      oe_r <= 1'b1;
    end else if (oe_clr_s) begin
      oe_r <= 1'b0;
    end else begin
      oe_r <= oe_r;
    end
  end

  // Read multiplexer, evaluated from addr every cycle independent of cs/rd
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (addr)
      UART_LSR: rd_mux_s = lsr_pack(oe_r, fifo_empty_s,
                                    fifo_empty_s & (state_r == ST_IDLE));
      UART_LVL: rd_mux_s = {{(31-FIFO_LOG2){1'b0}}, fifo_count_s};
      default:  rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Registered read data and the alternating rvalid pulse
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rdata_r  <= 32'h0000_0000;
      rvalid_r <= 1'b0;
    end else begin
      rdata_r  <= rd_mux_s;
      rvalid_r <= rd & ~rvalid_r;
    end
  end

  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;
  assign tx     = tx_r;
  assign irq    = fifo_empty_s;

endmodule
